axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder (slave end) that terminates the MASTER side of `axi_intf` and exposes a bank of `NUM_REGS` software-visible read/write registers. Write address and write data are accepted independently, in either order. One write and one read may be in flight at once. The register contents are also driven out in parallel so surrounding fabric can use them as control registers.

---
 rtl/axi_lite_reg_slave.sv | 166 ++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank responder: NUM_REGS read/write registers with byte strobes,
// independent write/read paths, register contents also exported flat on reg_q.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic                           AWVALID,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  output logic                           AWREADY,
  input  logic                           WVALID,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           WREADY,
  output logic                           BVALID,
  output logic [1:0]                     BRESP,
  input  logic                           BREADY,
  input  logic                           ARVALID,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           ARREADY,
  output logic                           RVALID,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDXW   = ADDR_WIDTH - LSB;
  localparam int unsigned SELW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t               w_state, w_state_d;
  rstate_t               r_state, r_state_d;
  logic                  aw_held, aw_held_d;
  logic                  w_held, w_held_d;
  logic [IDXW-1:0]       aw_idx, aw_idx_d;
  logic [DATA_WIDTH-1:0] w_data, w_data_d;
  logic [STRB_W-1:0]     w_strb, w_strb_d;
  logic [1:0]            bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [IDXW-1:0] ar_idx;
  logic [SELW-1:0] aw_sel, ar_sel;
  logic            aw_in_range, ar_in_range;
  logic            unused_addr_lsb;

  // Byte offset bits never participate in decode.
  assign unused_addr_lsb = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  assign ar_idx      = ARADDR[ADDR_WIDTH-1:LSB];
  assign aw_sel      = aw_idx[SELW-1:0];
  assign ar_sel      = ar_idx[SELW-1:0];
  assign aw_in_range = (aw_idx < IDXW'(NUM_REGS));
  assign ar_in_range = (ar_idx < IDXW'(NUM_REGS));

  assign BVALID  = (w_state == W_RESP);
  assign RVALID  = (r_state == R_DATA);
  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !RVALID;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  // Next-state for both paths; reads see regs_q so a same-cycle write is not visible yet.
  always_comb begin
    w_state_d = w_state;
    r_state_d = r_state;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    aw_idx_d  = aw_idx;
    w_data_d  = w_data;
    w_strb_d  = w_strb;
    bresp_d   = BRESP;
    rresp_d   = RRESP;
    rdata_d   = RDATA;
    regs_d    = regs_q;

    if (AWVALID && AWREADY) begin
      aw_held_d = 1'b1;
      aw_idx_d  = AWADDR[ADDR_WIDTH-1:LSB];
    end
    if (WVALID && WREADY) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    case (w_state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          if (aw_in_range) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (w_strb[k]) regs_d[aw_sel][8*k +: 8] = w_data[8*k +: 8];
            end
          end
          bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    case (r_state)
      R_IDLE: begin
        if (ARVALID) begin
          rdata_d   = ar_in_range ? regs_q[ar_sel] : '0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      BRESP   <= RESP_OKAY;
      RRESP   <= RESP_OKAY;
      RDATA   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
      aw_idx  <= aw_idx_d;
      w_data  <= w_data_d;
      w_strb  <= w_strb_d;
      BRESP   <= bresp_d;
      RRESP   <= rresp_d;
      RDATA   <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed vector table, hand-timed corner sequences,
// and random traffic against an array-based register model.
module tb_axi_lite_reg_slave;

  logic         aclk, areset_n;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [127:0] reg_q;

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .reg_q(reg_q)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] mem [4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vec [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Register model: word index = addr/4, four words, byte-lane merge.
  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
    int unsigned idx;
    idx = addr / 4;
    if (idx >= 4) return 2'b10;
    for (int k = 0; k < 4; k++)
      if (strb[k]) mem[idx][8*k +: 8] = data[8*k +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] m_read(input logic [31:0] addr);
    int unsigned idx;
    idx = addr / 4;
    if (idx >= 4) return {2'b10, 32'h0};
    return {2'b00, mem[idx]};
  endfunction

  function automatic logic [127:0] m_flat();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bp, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin @(negedge aclk); n++; end
    check("wr_addr_data_ready", {AWREADY, WREADY}, 2'b11);
    @(negedge aclk);
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge aclk); n++; end
    check("wr_bvalid_seen", BVALID, 1'b1);
    repeat (bp) @(negedge aclk);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge aclk);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int bp,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    ARVALID = 1'b1; ARADDR = addr;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge aclk); n++; end
    check("rd_arready", ARREADY, 1'b1);
    @(negedge aclk);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge aclk); n++; end
    check("rd_rvalid_seen", RVALID, 1'b1);
    repeat (bp) @(negedge aclk);
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge aclk);
    RREADY = 1'b0;
  endtask

  // Decoupled write: first channel, then the other three cycles later.
  task automatic decoupled(input bit aw_first, input logic [31:0] addr, input logic [31:0] data);
    int unsigned idx;
    idx = addr / 4;
    @(negedge aclk);
    if (aw_first) begin AWVALID = 1'b1; AWADDR = addr; end
    else begin WVALID = 1'b1; WDATA = data; WSTRB = 4'hF; end
    @(negedge aclk);
    check(aw_first ? "dec_awready_drop" : "dec_wready_drop", aw_first ? AWREADY : WREADY, 1'b0);
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (2) @(negedge aclk);
    check("dec_no_early_commit", {BVALID, reg_q[idx*32 +: 32]}, {1'b0, mem[idx]});
    if (aw_first) begin WVALID = 1'b1; WDATA = data; WSTRB = 4'hF; end
    else begin AWVALID = 1'b1; AWADDR = addr; end
    @(negedge aclk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("dec_bvalid_low_after_hs", BVALID, 1'b0);
    @(negedge aclk);
    void'(m_write(addr, data, 4'hF));
    check("dec_commit", {BVALID, BRESP, reg_q}, {1'b1, 2'b00, m_flat()});
    BREADY = 1'b1;
    @(negedge aclk);
    BREADY = 1'b0;
    check("dec_bvalid_clear", {BVALID, AWREADY, WREADY}, 3'b011);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, old;
    logic [33:0] exp_r;
    logic [1:0]  exp_b;

    areset_n = 1'b0;
    AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;

    vec[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vec[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vec[2]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vec[3]  = '{1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
    vec[4]  = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
    vec[5]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vec[6]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b10, 32'h0};
    vec[7]  = '{1'b0, 32'h07, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vec[8]  = '{1'b1, 32'h0C, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vec[9]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
    vec[10] = '{1'b1, 32'h0E, 32'h0000A5A5, 4'h3, 2'b00, 32'h0};
    vec[11] = '{1'b0, 32'h0F, 32'h0,        4'h0, 2'b00, 32'h0000A5A5};
    vec[12] = '{1'b0, 32'h13, 32'h0,        4'h0, 2'b10, 32'h0};

    repeat (3) @(negedge aclk);
    check("reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0});
    check("reset_reg_q", reg_q, 128'h0);
    areset_n = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 13; i++) begin
      if (vec[i].wr) begin
        do_write(vec[i].addr, vec[i].data, vec[i].strb, 0, resp);
        void'(m_write(vec[i].addr, vec[i].data, vec[i].strb));
        check($sformatf("vec%0d_bresp", i), resp, vec[i].exp_resp);
        check($sformatf("vec%0d_reg_q", i), reg_q, m_flat());
      end else begin
        do_read(vec[i].addr, 0, d, resp);
        check($sformatf("vec%0d_read", i), {resp, d}, {vec[i].exp_resp, vec[i].exp_rdata});
      end
    end
    check("vec_final_reg_q", reg_q, {32'h0000A5A5, 32'h0, 32'hDEADBEEF, 32'h11BB33DD});

    // Write latency: AW+W at one edge, BVALID and reg_q exactly one edge later.
    @(negedge aclk);
    AWVALID = 1'b1; AWADDR = 32'h8; WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    @(negedge aclk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("lat_after_hs", {BVALID, AWREADY, WREADY, reg_q[95:64]}, {3'b000, 32'h0});
    @(negedge aclk);
    void'(m_write(32'h8, 32'hCAFEF00D, 4'hF));
    check("lat_commit", {BVALID, BRESP, reg_q}, {1'b1, 2'b00, m_flat()});
    BREADY = 1'b1;
    @(negedge aclk);
    BREADY = 1'b0;
    check("lat_b_done", {BVALID, AWREADY, WREADY}, 3'b011);

    decoupled(1'b0, 32'h8, 32'h01020304);
    decoupled(1'b1, 32'hC, 32'h0A0B0C0D);

    // Read hits the commit edge of a write to the same register: old value returned.
    old = mem[2];
    @(negedge aclk);
    AWVALID = 1'b1; AWADDR = 32'h8; WVALID = 1'b1; WDATA = 32'h0BADC0DE; WSTRB = 4'hF;
    @(negedge aclk);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h8;
    @(negedge aclk);
    ARVALID = 1'b0;
    check("raw_same_cycle", {RVALID, RDATA, BVALID}, {1'b1, old, 1'b1});
    void'(m_write(32'h8, 32'h0BADC0DE, 4'hF));
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge aclk);
    RREADY = 1'b0; BREADY = 1'b0;
    do_read(32'h8, 0, d, resp);
    check("raw_new_value", {resp, d}, {2'b00, 32'h0BADC0DE});

    // Backpressure on B: stalled SLVERR response stays put, no new writes accepted.
    @(negedge aclk);
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'h55555555; WSTRB = 4'hF;
    @(negedge aclk);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge aclk);
    for (int c = 0; c < 5; c++) begin
      check("bp_b_stall", {BVALID, BRESP, AWREADY, WREADY, reg_q}, {1'b1, 2'b10, 2'b00, m_flat()});
      @(negedge aclk);
    end
    BREADY = 1'b1;
    @(negedge aclk);
    BREADY = 1'b0;
    check("bp_b_release", {BVALID, AWREADY, WREADY}, 3'b011);

    // Backpressure on R.
    @(negedge aclk);
    ARVALID = 1'b1; ARADDR = 32'h8;
    @(negedge aclk);
    ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_r_stall", {RVALID, RRESP, RDATA, ARREADY}, {1'b1, 2'b00, mem[2], 1'b0});
      @(negedge aclk);
    end
    RREADY = 1'b1;
    @(negedge aclk);
    RREADY = 1'b0;
    check("bp_r_release", {RVALID, ARREADY}, 2'b01);

    // Reset while an address is held and data is still outstanding.
    @(negedge aclk);
    AWVALID = 1'b1; AWADDR = 32'h4;
    @(negedge aclk);
    AWVALID = 1'b0;
    check("midrst_aw_held", {AWREADY, WREADY}, 2'b01);
    #2 areset_n = 1'b0;
    #1;
    check("midrst_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0});
    check("midrst_reg_q", reg_q, 128'h0);
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    @(negedge aclk);
    areset_n = 1'b1;
    do_read(32'h4, 0, d, resp);
    check("midrst_read_zero", {resp, d}, 34'h0);

    // Random traffic against the model, including out-of-range addresses and stalls.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a, wd;
      logic [3:0]  st;
      int          bp;
      a  = 32'($urandom_range(0, 23));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      bp = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        exp_b = m_write(a, wd, st);
        do_write(a, wd, st, bp, resp);
        check("rnd_bresp", resp, exp_b);
        check("rnd_reg_q", reg_q, m_flat());
      end else begin
        exp_r = m_read(a);
        do_read(a, bp, d, resp);
        check("rnd_read", {resp, d}, exp_r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
